zld_xc: RTL
===========

Name: zld_xc

Overview:
- Zero run-length decoder; the inverse of the zle_xc5 encoder.
- Consumes 4-bit tokens and expands each zero-run token into a sequence of 3-bit zero samples; literal tokens pass through as one sample.
- Sits downstream of the encoder in the TDF stream pipeline. Uses the same valid/back-pressure stream handshake on both sides.
- Hand-coded FSM plus a small datapath (run counter, output register); no EOS handling.

Parameters:
- W, 3, sample width. Token width is W+1.

Ports:
- clock, input, 1, single clock; all state changes on the rising edge.
- reset, input, 1, synchronous, active-low. reset=0 at a rising edge clears all state.
- i_d, input, W+1, token. Bit W=0 means a literal sample i_d[W-1:0]. Bit W=1 means a zero run of length i_d[W-1:0]+1 (1..2^W).
- i_v, input, 1, token valid.
- i_b, output, 1, back-pressure to the upstream producer (1 = cannot accept).
- o_d, output, W, decoded sample.
- o_v, output, 1, sample valid.
- o_b, input, 1, back-pressure from the downstream consumer (1 = stall).

Behaviour:
- Transfer rules: an input transfer occurs when i_v=1 and i_b=0 at a clock edge. An output transfer occurs when o_v=1 and o_b=0.
- Reset (reset=0 at an edge): state=EMPTY, o_v=0, o_d=0, cnt=0. i_b=0 in the following cycle. Reset overrides any in-progress run; the remaining zeros are discarded and no partial output survives.
- Datapath registers:
  - o_d/o_v: the one-entry output register.
  - cnt: W-bit count of zeros still owed after the one currently in o_d.
- FSM states:
  - EMPTY: o_v=0.
  - HOLD: o_v=1, cnt=0.
  - RUN: o_v=1, cnt>0; o_d=0.
- i_b is combinational: i_b = !(state==EMPTY || (state==HOLD && o_b==0)). An input can be accepted in the same cycle the last owed sample drains, giving full throughput.
- Token load (input transfer while EMPTY, or while HOLD and draining):
  - Literal token: o_d<=i_d[W-1:0], o_v<=1, state<=HOLD.
  - Run token with length L: o_d<=0, o_v<=1, cnt<=L-1, state<=(L==1 ? HOLD : RUN).
  - A literal token with value 0 is legal and emits a single zero.
- RUN, output transfer: o_d stays 0, cnt<=cnt-1. When cnt was 1, state<=HOLD.
- RUN, o_b=1: everything holds. i_b=1.
- HOLD, output transfer, no input transfer: o_v<=0, state<=EMPTY.
- Any stall (o_b=1): o_d, o_v, cnt and state are stable. o_d must not change while o_v=1 and o_b=1.
- Latency: the first sample appears 1 cycle after the token is accepted.
- Throughput: a run of length L occupies exactly L output-transfer cycles, with no bubbles between consecutive tokens when o_b=0 and i_v=1.
- Maximum-length run: token 4'b1111 (W=3) gives 8 zeros. cnt loads 7 with no wrap. cnt never underflows because decrement only occurs for cnt>0.
- i_d is ignored when i_v=0. i_v is ignored while i_b=1.

Test Plan:
- Reset then tokens 0x5, 0x3, 0x1 (literals), o_b=0, i_v=1 continuously → o_d=5,3,1 on consecutive cycles starting 1 cycle after the first accept; i_b=0 throughout.
- Token 0xA (run of 3) then 0x6 → o_d=0,0,0,6 back-to-back. i_b=1 for exactly 2 cycles, then low in the cycle the third zero drains.
- Token 0xF then 0x8 (runs of 8 and 1) → 9 consecutive zeros. Exactly 9 output transfers; cnt never wraps.
- Run token 0xB (4 zeros) with o_b=1 on cycles 2 and 3 of output → 4 zeros total. o_d/o_v stable during the stall; the next literal 0x2 appears only after the fourth zero transfers.
- Assert reset=0 mid-run of 0xE (7 zeros) after 2 zeros are delivered → the next cycle has o_v=0, i_b=0. The following token 0x4 outputs 4 with no stray zeros.
- Randomised encoder-to-decoder loopback (zle_xc5 feeding zld_xc) with random o_b → the 3-bit output sequence equals the encoder input sequence exactly.

Source files
------------

// File: rtl/zld_xc.sv
// Zero run-length decoder: expands (W+1)-bit tokens into W-bit samples.
// Literal tokens pass through as one sample. Run tokens emit len zeros.
// Both ports use a valid/back-pressure handshake. A new token can load in
// the cycle the last owed sample drains, so there are no bubbles.
module zld_xc #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W:0]   i_d,
  input  logic         i_v,
  output logic         i_b,
  output logic [W-1:0] o_d,
  output logic         o_v,
  input  logic         o_b
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    RUN   = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   od_q, od_d;
  logic           ov_q, ov_d;
  logic [W-1:0]   cnt_q, cnt_d;

  logic           in_xfer;
  logic           out_xfer;
  logic           tok_run;
  logic [W-1:0]   tok_val;

  assign tok_run  = i_d[W];
  assign tok_val  = i_d[W-1:0];
  assign in_xfer  = i_v & ~i_b;
  assign out_xfer = o_v & ~o_b;

  // State and datapath registers; reset drops any run in progress.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= EMPTY;
      od_q    <= '0;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      od_q    <= od_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: token load has priority; otherwise drain HOLD/RUN on transfer.
  always_comb begin
    state_d = state_q;
    od_d    = od_q;
    ov_d    = ov_q;
    cnt_d   = cnt_q;
    if (in_xfer) begin
      // Only reachable from EMPTY or a draining HOLD.
      ov_d = 1'b1;
      if (tok_run) begin
        // Field holds len-1, which is exactly the zeros owed after this one.
        od_d    = '0;
        cnt_d   = tok_val;
        state_d = (tok_val == '0) ? HOLD : RUN;
      end else begin
        od_d    = tok_val;
        cnt_d   = '0;
        state_d = HOLD;
      end
    end else if (out_xfer) begin
      unique case (state_q)
        HOLD: begin
          ov_d    = 1'b0;
          state_d = EMPTY;
        end
        RUN: begin
          // cnt > 0 in RUN, so the decrement cannot wrap.
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == {{(W-1){1'b0}}, 1'b1}) state_d = HOLD;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs: registered sample; i_b opens when empty or when HOLD drains now.
  always_comb begin
    o_d = od_q;
    o_v = ov_q;
    i_b = !((state_q == EMPTY) || ((state_q == HOLD) && !o_b));
  end

endmodule
